// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART memory loader: header field layout,
// status reply codes and the command FSM state encoding.
package uart_mem_loader_pkg;

  localparam int HDR_WR_BIT   = 31;
  localparam int HDR_TGT_LSB  = 28;
  localparam int HDR_TGT_W    = 3;
  localparam int HDR_ADDR_LSB = 16;
  localparam int HDR_CNT_LSB  = 0;
  localparam int HDR_CNT_W    = 16;

  localparam logic [7:0] STATUS_OK  = 8'hA5;
  localparam logic [7:0] STATUS_BAD = 8'h5A;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_WR_DATA,
    ST_WR_CSUM,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_SEND,
    ST_STATUS
  } state_e;

endpackage

// File: rtl/uart_word_assembler.sv
// Packs received UART bytes LSB-first into words of a selectable byte length
// and flags an inter-byte idle timeout while a word is owed.
module uart_word_assembler #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  enable,
  input  logic                  arm,
  input  logic [3:0]            word_bytes,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid,
  output logic                  timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    byte_idx;
  logic [TW-1:0] idle_cnt;
  logic          accept;

  assign accept = enable && rx_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx   <= '0;
      idle_cnt   <= '0;
      word_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      timeout    <= 1'b0;
      if (accept) begin
        idle_cnt <= '0;
        if ({1'b0, byte_idx} == word_bytes - 4'd1) begin
          byte_idx   <= '0;
          word_valid <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 3'd1;
        end
      end else if (arm || byte_idx != 3'd0) begin
        // A partial word is dropped on timeout so the next command starts clean.
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          idle_cnt <= '0;
          byte_idx <= '0;
          timeout  <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // NOTE: the assembly register carries no reset; word_valid alone says when it is meaningful.
  always_ff @(posedge clk) begin
    if (accept) word[byte_idx*8 +: 8] <= rx_data;
  end

endmodule

// File: rtl/uart_mem_loader.sv
// UART command engine: decodes header words from the byte assembler, drives
// per-target memory strobes and serialises read data or a status byte back out.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int NUM_TGT        = 2,
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int CHECKSUM_EN    = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_TGT-1:0]            mem_we,
  output logic [NUM_TGT-1:0]            mem_re,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [NUM_TGT*DATA_WIDTH-1:0] mem_rdata,
  output logic                          cpu_hold,
  output logic                          err,
  output logic                          busy
);

  localparam int                 BYTES      = DATA_WIDTH / 8;
  localparam logic [3:0]         WORD_BYTES = 4'(BYTES);
  localparam logic [3:0]         NUM_TGT_L  = 4'(NUM_TGT);
  localparam logic [NUM_TGT-1:0] TGT_ONE    = NUM_TGT'(1);

  state_e                  state;
  logic [2:0]              tgt;
  logic                    tgt_ok;
  logic                    csum_ok;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [15:0]             remaining;
  logic [31:0]             csum;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   rd_slice;
  logic [2:0]              byte_idx;
  logic                    rd_wait_done;

  logic [DATA_WIDTH-1:0]   asm_word;
  logic                    asm_valid;
  logic                    asm_timeout;
  logic                    asm_enable;
  logic                    asm_arm;
  logic [3:0]              asm_bytes;
  logic [2:0]              hdr_tgt;
  logic [15:0]             hdr_cnt;
  logic                    hdr_tgt_ok;

  assign asm_enable = state inside {ST_HDR, ST_WR_DATA, ST_WR_CSUM};
  assign asm_arm    = state inside {ST_WR_DATA, ST_WR_CSUM};
  assign asm_bytes  = (state == ST_WR_DATA) ? WORD_BYTES : 4'd4;
  assign hdr_tgt    = asm_word[HDR_TGT_LSB +: HDR_TGT_W];
  assign hdr_cnt    = asm_word[HDR_CNT_LSB +: HDR_CNT_W];
  assign hdr_tgt_ok = {1'b0, hdr_tgt} < NUM_TGT_L;
  assign busy       = cpu_hold;

  uart_word_assembler #(
    .DATA_WIDTH     (DATA_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .enable     (asm_enable),
    .arm        (asm_arm),
    .word_bytes (asm_bytes),
    .word       (asm_word),
    .word_valid (asm_valid),
    .timeout    (asm_timeout)
  );

  // Invalid targets read back as zero.
  always_comb begin
    rd_slice = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      if (tgt == 3'(t)) rd_slice = mem_rdata[t*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_HDR;
      tgt          <= '0;
      tgt_ok       <= 1'b0;
      csum_ok      <= 1'b0;
      addr         <= '0;
      remaining    <= '0;
      csum         <= '0;
      byte_idx     <= '0;
      rd_wait_done <= 1'b0;
      mem_we       <= '0;
      mem_re       <= '0;
      mem_addr     <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      err          <= 1'b0;
      cpu_hold     <= 1'b0;
    end else begin
      mem_we <= '0;
      mem_re <= '0;
      err    <= 1'b0;
      if (asm_timeout) begin
        err      <= 1'b1;
        cpu_hold <= 1'b0;
        state    <= ST_HDR;
      end else begin
        case (state)
          ST_HDR: begin
            if (asm_valid) begin
              tgt       <= hdr_tgt;
              tgt_ok    <= hdr_tgt_ok;
              addr      <= asm_word[HDR_ADDR_LSB +: ADDR_WIDTH];
              remaining <= hdr_cnt;
              csum      <= '0;
              csum_ok   <= (CHECKSUM_EN == 0);
              if (hdr_cnt == 16'd0) begin
                cpu_hold <= 1'b0;
              end else if (asm_word[HDR_WR_BIT]) begin
                state <= ST_WR_DATA;
              end else begin
                state <= ST_RD_ISSUE;
                if (!hdr_tgt_ok) err <= 1'b1;
              end
            end
            if (rx_valid) cpu_hold <= 1'b1;
          end
          ST_WR_DATA: begin
            if (asm_valid) begin
              csum      <= csum + asm_word[31:0];
              if (tgt_ok) mem_we <= TGT_ONE << tgt;
              mem_addr  <= addr;
              mem_wdata <= asm_word;
              addr      <= addr + ADDR_WIDTH'(1);
              remaining <= remaining - 16'd1;
              if (remaining == 16'd1) state <= (CHECKSUM_EN != 0) ? ST_WR_CSUM : ST_STATUS;
            end
          end
          ST_WR_CSUM: begin
            if (asm_valid) begin
              csum_ok <= (asm_word[31:0] == csum);
              state   <= ST_STATUS;
            end
          end
          ST_STATUS: begin
            if (!tx_valid) begin
              tx_valid <= 1'b1;
              tx_data  <= (tgt_ok && csum_ok) ? STATUS_OK : STATUS_BAD;
              if (!(tgt_ok && csum_ok)) err <= 1'b1;
            end else if (tx_ready) begin
              tx_valid <= 1'b0;
              cpu_hold <= 1'b0;
              state    <= ST_HDR;
            end
          end
          ST_RD_ISSUE: begin
            if (tgt_ok) mem_re <= TGT_ONE << tgt;
            mem_addr     <= addr;
            rd_wait_done <= 1'b0;
            state        <= ST_RD_WAIT;
          end
          ST_RD_WAIT: begin
            // First cycle is the strobe itself; the slice is valid on the second.
            if (!rd_wait_done) begin
              rd_wait_done <= 1'b1;
            end else begin
              rd_word  <= rd_slice;
              byte_idx <= '0;
              state    <= ST_RD_SEND;
            end
          end
          ST_RD_SEND: begin
            if (!tx_valid) begin
              tx_valid <= 1'b1;
              tx_data  <= rd_word[7:0];
            end else if (tx_ready) begin
              tx_valid <= 1'b0;
              rd_word  <= rd_word >> 8;
              if (byte_idx == 3'(BYTES - 1)) begin
                byte_idx  <= '0;
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - 16'd1;
                if (remaining == 16'd1) begin
                  cpu_hold <= 1'b0;
                  state    <= ST_HDR;
                end else begin
                  state <= ST_RD_ISSUE;
                end
              end else begin
                byte_idx <= byte_idx + 3'd1;
              end
            end
          end
          default: state <= ST_HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomised scoreboard bench for uart_mem_loader: a command-level reference
// model queues expected TX bytes and memory writes; monitors compare them.
module tb_uart_mem_loader;

  localparam int NUM_TGT = 2;
  localparam int AW      = 11;
  localparam int DW      = 32;
  localparam int CSUM    = 1;
  localparam int TMO     = 200;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [7:0]            rx_data = '0;
  logic                  rx_valid = 1'b0;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready = 1'b0;
  logic [NUM_TGT-1:0]    mem_we, mem_re;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic [NUM_TGT*DW-1:0] mem_rdata = '0;
  logic                  cpu_hold, err, busy;

  always #5 clk = ~clk;

  uart_mem_loader #(
    .NUM_TGT(NUM_TGT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .CHECKSUM_EN(CSUM), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .err(err), .busy(busy)
  );

  // Target memories seen by the DUT, plus the reference model's own copy.
  logic [DW-1:0] phys    [NUM_TGT][2**AW] = '{default: '0};
  logic [31:0]   ref_mem [NUM_TGT][2**AW] = '{default: '0};
  logic          pl_en = 1'b0;
  int            pl_t = 0, pl_a = 0;
  logic [DW-1:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_en) phys[pl_t][pl_a] <= pl_d;
    for (int t = 0; t < NUM_TGT; t++) begin
      if (mem_we[t]) phys[t][mem_addr] <= mem_wdata;
      if (mem_re[t]) mem_rdata[t*DW +: DW] <= phys[t][mem_addr];
    end
  end

  logic [7:0]  exp_tx[$];
  logic [63:0] exp_wr[$];
  logic [31:0] payload[$];
  int total = 0, bad = 0, err_seen = 0, err_exp = 0, popped = 0;
  int ready_pct = 50;
  bit hold_ready = 1'b0;
  bit stalled = 1'b0;
  logic [7:0] stall_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] wr_key(input int t, input int a, input logic [31:0] d);
    logic [NUM_TGT-1:0] oh;
    oh    = '0;
    oh[t] = 1'b1;
    return 64'({oh, AW'(a), d});
  endfunction

  function automatic logic [31:0] mk_hdr(input bit w, input int t, input int a, input int c);
    return {w, 3'(t), 12'(a), 16'(c)};
  endfunction

  // Monitor: scoreboard pops for TX handshakes and memory writes, counts err pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_seen++;
      if (mem_we != '0) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: we=0x%0h addr=0x%0h data=0x%0h", mem_we, mem_addr, mem_wdata);
        end else begin
          check("mem_write", 64'({mem_we, mem_addr, mem_wdata}), exp_wr.pop_front());
        end
      end
      if (tx_valid) begin
        if (stalled) check("tx_hold_stable", tx_data, stall_data);
        if (tx_ready) begin
          stalled = 1'b0;
          popped++;
          if (exp_tx.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_tx: byte 0x%0h with nothing expected", tx_data);
          end else begin
            check("tx_byte", tx_data, exp_tx.pop_front());
          end
        end else begin
          stalled    = 1'b1;
          stall_data = tx_data;
        end
      end else begin
        stalled = 1'b0;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!hold_ready) tx_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  task automatic send_word32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(8'((w >> (8 * i)) & 32'hFF));
  endtask

  task automatic preload(input int t, input int a, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_t = t; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[t][a] = d;
  endtask

  // Reference model for a write: all expectations follow from the command alone.
  task automatic issue_write(input logic [31:0] hdr, input bit use_csum, input logic [31:0] csum_val);
    int t = int'((hdr >> 28) & 32'h7);
    int a = int'((hdr >> 16) & 32'hFFF);
    int c = int'(hdr & 32'hFFFF);
    logic [31:0] sum = '0;
    logic [31:0] sent;
    for (int i = 0; i < c; i++) begin
      sum += payload[i];
      if (t < NUM_TGT) begin
        int wa = (a + i) % (2**AW);
        exp_wr.push_back(wr_key(t, wa, payload[i]));
        ref_mem[t][wa] = payload[i];
      end
    end
    sent = use_csum ? csum_val : sum;
    if (c > 0) begin
      if (t < NUM_TGT && sent == sum) exp_tx.push_back(8'hA5);
      else begin
        exp_tx.push_back(8'h5A);
        err_exp++;
      end
    end
    send_word32(hdr);
    for (int i = 0; i < c; i++) send_word32(payload[i]);
    if (c > 0) send_word32(sent);
  endtask

  task automatic issue_read(input logic [31:0] hdr);
    int t = int'((hdr >> 28) & 32'h7);
    int a = int'((hdr >> 16) & 32'hFFF);
    int c = int'(hdr & 32'hFFFF);
    if (c > 0 && t >= NUM_TGT) err_exp++;
    for (int i = 0; i < c; i++) begin
      logic [31:0] w = (t < NUM_TGT) ? ref_mem[t][(a + i) % (2**AW)] : 32'h0;
      for (int j = 0; j < 4; j++) exp_tx.push_back(8'((w >> (8 * j)) & 32'hFF));
    end
    send_word32(hdr);
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!cpu_hold && exp_tx.size() == 0 && exp_wr.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done"}, 64'(ok), 64'd1);
    check({name, "_err_count"}, 64'(err_seen), 64'(err_exp));
    check({name, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_hold", {cpu_hold, busy, err}, 0);
    check("reset_strobes", {mem_we, mem_re}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    preload(0, 16, 32'hA0A1A2A3);
    preload(0, 17, 32'hB0B1B2B3);
    preload(0, 18, 32'hC0C1C2C3);

    payload = '{32'h11223344, 32'h55667788};
    issue_write(32'h80000002, 1'b1, 32'h6688AACC);
    wait_done("wr_good_csum");

    issue_write(32'h80000002, 1'b1, 32'h00000000);
    wait_done("wr_bad_csum");

    issue_read(32'h00100003);
    wait_done("rd_three_words");

    payload = '{$urandom, $urandom};
    issue_write(32'h87FF0002, 1'b0, 32'h0);
    wait_done("wr_addr_wrap");

    payload = '{$urandom};
    issue_write(32'hD0000001, 1'b0, 32'h0);
    wait_done("wr_bad_target");

    payload.delete();
    issue_write(32'h80000000, 1'b0, 32'h0);
    wait_done("wr_zero_count");

    issue_read(mk_hdr(1'b0, 3, 5, 2));
    wait_done("rd_bad_target");

    // Long TX back-pressure must not time out.
    ready_pct = 0;
    issue_read(mk_hdr(1'b0, 1, $urandom_range(0, 4095), 2));
    repeat (TMO * 3) @(posedge clk);
    @(negedge clk);
    check("stall_no_err", 64'(err_seen), 64'(err_exp));
    check("stall_tx_valid", tx_valid, 1);
    check("stall_hold", cpu_hold, 1);
    ready_pct = 60;
    wait_done("rd_after_stall");

    // Partial header then silence.
    send_byte(8'h02);
    send_byte(8'h00);
    err_exp++;
    repeat (TMO + 8) @(posedge clk);
    @(negedge clk);
    check("hdr_timeout_err", 64'(err_seen), 64'(err_exp));
    check("hdr_timeout_hold", cpu_hold, 0);
    payload = '{$urandom};
    issue_write(mk_hdr(1'b1, 1, 700, 1), 1'b0, 32'h0);
    wait_done("wr_after_timeout");

    // Payload timeout after one committed write; that write must persist.
    begin
      logic [31:0] w = $urandom;
      exp_wr.push_back(wr_key(1, 100, w));
      ref_mem[1][100] = w;
      err_exp++;
      send_word32(mk_hdr(1'b1, 1, 100, 2));
      send_word32(w);
      repeat (TMO + 8) @(posedge clk);
      @(negedge clk);
      check("pay_timeout_err", 64'(err_seen), 64'(err_exp));
      check("pay_timeout_hold", cpu_hold, 0);
      issue_read(mk_hdr(1'b0, 1, 100, 1));
      wait_done("rd_committed");
    end

    for (int n = 0; n < 8; n++) begin
      int t = $urandom_range(0, 2);
      int a = $urandom_range(0, 4095);
      int c = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        payload.delete();
        for (int i = 0; i < c; i++) payload.push_back($urandom);
        if ($urandom_range(0, 3) == 0) issue_write(mk_hdr(1'b1, t, a, c), 1'b1, $urandom);
        else issue_write(mk_hdr(1'b1, t, a, c), 1'b0, 32'h0);
      end else begin
        issue_read(mk_hdr(1'b0, t, a, c));
      end
      wait_done("rand_cmd");
    end

    // Reset in the middle of a read.
    ready_pct = 50;
    begin
      int p0 = popped;
      bit got = 1'b0;
      issue_read(mk_hdr(1'b0, 0, 16, 3));
      for (int i = 0; i < 5000; i++) begin
        @(negedge clk);
        if (popped >= p0 + 3) begin
          got = 1'b1;
          break;
        end
      end
      check("rst_read_progress", 64'(got), 64'd1);
    end
    @(posedge clk); #2;
    hold_ready = 1'b1;
    tx_ready   = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_tx_valid", tx_valid, 0);
    check("rst_mid_hold", cpu_hold, 0);
    check("rst_mid_strobes", {mem_we, mem_re}, 0);
    exp_tx.delete();
    rst_n      = 1'b1;
    hold_ready = 1'b0;
    issue_read(mk_hdr(1'b0, 0, 17, 2));
    wait_done("rd_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
